// File: rtl/mult_dot_accumulator.sv
// Dot-product accumulator: sums LEN products per group and hands each sum to a one-deep valid/ready register.
// Define MULT_DOT_SAT_EN to make the running sum saturate at 2^ACC_W-1; otherwise it wraps.
module mult_dot_accumulator #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16,
  parameter int LEN    = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              res_rdy,
  input  logic [PROD_W-1:0] res,
  input  logic              clr,
  output logic              acc_vld,
  input  logic              acc_rdy,
  output logic [ACC_W-1:0]  acc_out,
  output logic [7:0]        grp_idx,
  output logic              drop_err
);

  localparam logic [7:0] LAST_IDX = 8'(LEN - 1);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] out_q, out_d;
  logic [7:0]       grp_q, grp_d;
  logic             vld_q, vld_d;
  logic             drop_q, drop_d;

  logic [ACC_W-1:0] base;
  logic [ACC_W:0]   sum_wide;
  logic [ACC_W-1:0] sum_next;
  logic             out_free;
  logic             last_prod;

  // A clr in the same cycle starts a fresh group, so the partial sum never contributes.
  assign base     = (clr || grp_q == 8'd0) ? '0 : acc_q;
  assign sum_wide = {1'b0, base} + {{(ACC_W + 1 - PROD_W){1'b0}}, res};

`ifdef MULT_DOT_SAT_EN
  assign sum_next = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
  assign sum_next = sum_wide[ACC_W-1:0];
`endif

  assign out_free  = !vld_q || acc_rdy;
  assign last_prod = res_rdy && !clr && (grp_q == LAST_IDX);

  always_comb begin
    acc_d  = acc_q;
    out_d  = out_q;
    grp_d  = grp_q;
    vld_d  = vld_q;
    drop_d = drop_q;

    if (vld_q && acc_rdy) vld_d = 1'b0;

    if (clr) begin
      acc_d  = '0;
      grp_d  = 8'd0;
      drop_d = 1'b0;
    end

    if (last_prod) begin
      grp_d = 8'd0;
      if (out_free) begin
        out_d = sum_next;
        vld_d = 1'b1;
      end else begin
        drop_d = 1'b1;
      end
    end else if (res_rdy) begin
      acc_d = sum_next;
      grp_d = clr ? 8'd1 : grp_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_q  <= '0;
      out_q  <= '0;
      grp_q  <= 8'd0;
      vld_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      out_q  <= out_d;
      grp_q  <= grp_d;
      vld_q  <= vld_d;
      drop_q <= drop_d;
    end
  end

  assign acc_vld  = vld_q;
  assign acc_out  = out_q;
  assign grp_idx  = grp_q;
  assign drop_err = drop_q;

endmodule

// File: tb/tb_mult_dot_accumulator.sv
// Scoreboard bench for mult_dot_accumulator: expected sums queued by the stimulus, popped on each transfer.
module tb_mult_dot_accumulator;

  logic        clk = 1'b0;
  logic        rstn;
  logic        res_rdy, clr, acc_rdy;
  logic [7:0]  res;
  logic        acc_vld, drop_err;
  logic [15:0] acc_out;
  logic [7:0]  grp_idx;

  logic        res_rdy2, clr2, acc_rdy2;
  logic [7:0]  res2;
  logic        acc_vld2, drop_err2;
  logic [8:0]  acc_out2;
  logic [7:0]  grp_idx2;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  mult_dot_accumulator #(.PROD_W(8), .ACC_W(16), .LEN(4)) u_dut (
    .clk(clk), .rstn(rstn), .res_rdy(res_rdy), .res(res), .clr(clr),
    .acc_vld(acc_vld), .acc_rdy(acc_rdy), .acc_out(acc_out),
    .grp_idx(grp_idx), .drop_err(drop_err)
  );

  mult_dot_accumulator #(.PROD_W(8), .ACC_W(9), .LEN(4)) u_narrow (
    .clk(clk), .rstn(rstn), .res_rdy(res_rdy2), .res(res2), .clr(clr2),
    .acc_vld(acc_vld2), .acc_rdy(acc_rdy2), .acc_out(acc_out2),
    .grp_idx(grp_idx2), .drop_err(drop_err2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] v);
    res_rdy = 1'b1;
    res     = v;
    step();
    res_rdy = 1'b0;
    res     = 8'hxx;
  endtask

  task automatic pulse2(input logic [7:0] v);
    res_rdy2 = 1'b1;
    res2     = v;
    step();
    res_rdy2 = 1'b0;
  endtask

  // Monitor: every transfer must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rstn === 1'b1 && acc_vld === 1'b1 && acc_rdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got %0d expected no transfer", acc_out);
      end else begin
        chk("sb_acc_out", 32'(acc_out), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0; res_rdy = 1'b0; res = 8'd0; clr = 1'b0; acc_rdy = 1'b0;
    res_rdy2 = 1'b0; res2 = 8'd0; clr2 = 1'b0; acc_rdy2 = 1'b1;
    repeat (3) step();
    rstn = 1'b1;
    chk("rst_vld", 32'(acc_vld), 0);
    chk("rst_out", 32'(acc_out), 0);
    chk("rst_grp", 32'(grp_idx), 0);
    chk("rst_drop", 32'(drop_err), 0);

    // 1: basic group with gaps
    acc_rdy = 1'b1;
    exp_q.push_back(16'd100);
    pulse(8'd10); chk("t1_grp1", 32'(grp_idx), 1);
    step();
    pulse(8'd20); chk("t1_grp2", 32'(grp_idx), 2);
    pulse(8'd30); chk("t1_grp3", 32'(grp_idx), 3);
    chk("t1_vld_early", 32'(acc_vld), 0);
    pulse(8'd40);
    chk("t1_vld", 32'(acc_vld), 1);
    chk("t1_out", 32'(acc_out), 100);
    chk("t1_grp0", 32'(grp_idx), 0);
    step();
    chk("t1_vld_off", 32'(acc_vld), 0);

    // 2: output blocked, second group dropped
    acc_rdy = 1'b0;
    exp_q.push_back(16'd4);
    repeat (4) pulse(8'd1);
    chk("t2_vld1", 32'(acc_vld), 1);
    repeat (4) pulse(8'd2);
    chk("t2_drop", 32'(drop_err), 1);
    chk("t2_out_held", 32'(acc_out), 4);
    chk("t2_vld_held", 32'(acc_vld), 1);
    acc_rdy = 1'b1;
    step();
    acc_rdy = 1'b0;
    chk("t2_vld_off", 32'(acc_vld), 0);
    clr = 1'b1; step(); clr = 1'b0;
    chk("t2_drop_clr", 32'(drop_err), 0);

    // 3: transfer and completion in the same cycle
    exp_q.push_back(16'd4);
    exp_q.push_back(16'd8);
    repeat (4) pulse(8'd1);
    chk("t3_out1", 32'(acc_out), 4);
    repeat (3) pulse(8'd2);
    acc_rdy = 1'b1;
    pulse(8'd2);
    chk("t3_vld", 32'(acc_vld), 1);
    chk("t3_out2", 32'(acc_out), 8);
    chk("t3_drop", 32'(drop_err), 0);
    step();
    chk("t3_vld_off", 32'(acc_vld), 0);

    // 4: narrow accumulator, wrap or saturate
    repeat (4) pulse2(8'd225);
    chk("t4_vld", 32'(acc_vld2), 1);
`ifdef MULT_DOT_SAT_EN
    chk("t4_out", 32'(acc_out2), 511);
`else
    chk("t4_out", 32'(acc_out2), 388);
`endif

    // 5: clr coinciding with a product starts a new group
    pulse(8'd5); pulse(8'd5);
    chk("t5_grp2", 32'(grp_idx), 2);
    clr = 1'b1;
    pulse(8'd7);
    clr = 1'b0;
    chk("t5_grp1", 32'(grp_idx), 1);
    exp_q.push_back(16'd10);
    repeat (3) pulse(8'd1);
    chk("t5_out", 32'(acc_out), 10);
    step();

    // 6: reset mid-group with a held result
    acc_rdy = 1'b0;
    repeat (4) pulse(8'd1);
    chk("t6_vld_pre", 32'(acc_vld), 1);
    pulse(8'd9); pulse(8'd9);
    rstn = 1'b0; step(); rstn = 1'b1;
    chk("t6_vld", 32'(acc_vld), 0);
    chk("t6_out", 32'(acc_out), 0);
    chk("t6_grp", 32'(grp_idx), 0);
    chk("t6_drop", 32'(drop_err), 0);
    acc_rdy = 1'b1;
    exp_q.push_back(16'd12);
    repeat (4) pulse(8'd3);
    chk("t6_out2", 32'(acc_out), 12);
    step();
    chk("t6_vld_off", 32'(acc_vld), 0);

    repeat (2) step();
    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
